// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states, register address
// width default and branch-resolve stage codes.
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERROR    = 2'd2
    } hz_state_e;

    localparam int unsigned HZ_REG_ADDR_LEN = 5;

    localparam int unsigned HZ_BRANCH_ID = 1;
    localparam int unsigned HZ_BRANCH_EX = 2;

endpackage

// File: rtl/pipeline_hazard_unit_hazard_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and stall controller for the 5-stage pipeline: data hazards, data-memory wait with
// timeout, redirect flushes and saturating statistics. Define HAZ_FORWARD_EN when forwarding
// exists so that only load-use hazards stall.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_LEN = HZ_REG_ADDR_LEN,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned BRANCH_STAGE = HZ_BRANCH_EX,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC*REG_ADDR_LEN-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]              id_src_used,
    input  logic [REG_ADDR_LEN-1:0]         ex_dst,
    input  logic [REG_ADDR_LEN-1:0]         mem_dst,
    input  logic                            ex_reg_write,
    input  logic                            ex_mem_read,
    input  logic                            mem_reg_write,
    input  logic                            branch_taken,
    input  logic                            jump_taken,
    input  logic                            dmem_req,
    input  logic                            dmem_ready,
    output logic                            pc_stall,
    output logic                            if_id_stall,
    output logic                            if_id_flush,
    output logic                            id_ex_flush,
    output logic                            ex_mem_stall,
    output logic                            mem_wb_bubble,
    output logic                            mem_timeout,
    output logic [1:0]                      hz_state,
    output logic [CNT_W-1:0]                load_stalls,
    output logic [CNT_W-1:0]                mem_stalls,
    output logic [CNT_W-1:0]                flushes
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    hz_state_e        state_d, state_q;
    logic [WaitW-1:0] wait_d, wait_q;

    logic [REG_ADDR_LEN-1:0] src;
    logic load_use;
    logic data_hz;
    logic redirect;
    logic mem_stall;
    logic load_inc;
    logic flush_inc;

    // Register 0 is hard-wired, so it never creates a dependency.
    always_comb begin
        src      = '0;
        load_use = 1'b0;
        data_hz  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = id_src_addr[i*REG_ADDR_LEN +: REG_ADDR_LEN];
            if (id_src_used[i] && (src != '0)) begin
                if (ex_mem_read && ex_reg_write && (src == ex_dst)) begin
                    load_use = 1'b1;
                end
`ifndef HAZ_FORWARD_EN
                if (ex_reg_write && (src == ex_dst)) begin
                    data_hz = 1'b1;
                end
                if (mem_reg_write && (src == mem_dst)) begin
                    data_hz = 1'b1;
                end
`endif
            end
        end
        data_hz = data_hz | load_use;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            HZ_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d = HZ_MEM_WAIT;
                    wait_d  = WaitW'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = HZ_RUN;
                end else if (wait_q >= WaitW'(TIMEOUT)) begin
                    state_d = HZ_ERROR;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            HZ_ERROR: begin
                state_d = HZ_ERROR;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // The completing cycle in MEM_WAIT (dmem_ready high) already lets the pipeline advance.
    always_comb begin
        redirect  = branch_taken | jump_taken;
        mem_stall = (state_q == HZ_ERROR)
                  | ((state_q == HZ_MEM_WAIT) & ~dmem_ready)
                  | ((state_q == HZ_RUN) & dmem_req & ~dmem_ready);

        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        load_inc      = 1'b0;
        flush_inc     = 1'b0;

        if (mem_stall) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = (BRANCH_STAGE == HZ_BRANCH_EX);
            flush_inc   = 1'b1;
        end else if (data_hz) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            load_inc    = 1'b1;
        end
    end

    assign mem_timeout = (state_q == HZ_ERROR);
    assign hz_state    = state_q;

    hazard_sat_counter #(.W(CNT_W)) u_load_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (load_inc),
        .count_o (load_stalls)
    );

    hazard_sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (mem_stall),
        .count_o (mem_stalls)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (flush_inc),
        .count_o (flushes)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (EX-resolve/16-bit counters and
// ID-resolve/2-bit counters) driven in parallel, checked every cycle against a rule model.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [4:0] ex_dst, mem_dst;
    logic       ex_reg_write, ex_mem_read, mem_reg_write;
    logic       branch_taken, jump_taken, dmem_req, dmem_ready;

    logic        a_pc, a_ifs, a_iff, a_ief, a_ems, a_mwb, a_to;
    logic [1:0]  a_st;
    logic [15:0] a_ls, a_ms, a_fl;
    logic        b_pc, b_ifs, b_iff, b_ief, b_ems, b_mwb, b_to;
    logic [1:0]  b_st;
    logic [1:0]  b_ls, b_ms, b_fl;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .REG_ADDR_LEN(5), .NUM_SRC(2), .BRANCH_STAGE(2), .TIMEOUT(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_reg_write(mem_reg_write),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_flush(a_iff),
        .id_ex_flush(a_ief), .ex_mem_stall(a_ems), .mem_wb_bubble(a_mwb),
        .mem_timeout(a_to), .hz_state(a_st), .load_stalls(a_ls), .mem_stalls(a_ms),
        .flushes(a_fl)
    );

    pipeline_hazard_unit #(
        .REG_ADDR_LEN(5), .NUM_SRC(2), .BRANCH_STAGE(1), .TIMEOUT(4), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_reg_write(mem_reg_write),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_flush(b_iff),
        .id_ex_flush(b_ief), .ex_mem_stall(b_ems), .mem_wb_bubble(b_mwb),
        .mem_timeout(b_to), .hz_state(b_st), .load_stalls(b_ls), .mem_stalls(b_ms),
        .flushes(b_fl)
    );

    task automatic chk(input string name, input int dut, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, dut, got, exp,
                     $time);
        end
    endtask

    // Does the ID instruction read register r through any used operand?
    function automatic bit id_reads(input logic [4:0] r);
        for (int i = 0; i < 2; i++) begin
            if (id_src_used[i] && (id_src_addr[i*5 +: 5] == r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model state: mode 0 run, 1 waiting on memory, 2 timed out.
    int m_mode[2] = '{0, 0};
    int m_wait[2] = '{0, 0};
    int m_ls[2]   = '{0, 0};
    int m_ms[2]   = '{0, 0};
    int m_fl[2]   = '{0, 0};
    int bstage[2] = '{2, 1};
    int cmax[2]   = '{65535, 3};
    localparam int ModelTimeout = 4;

    always @(negedge clk) begin : cmp
        bit g_pc, g_ifs, g_iff, g_ief, g_ems, g_mwb, g_to;
        int g_st, g_ls, g_ms, g_fl;
        bit lu, dep, need, redir, frozen;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    g_pc = a_pc; g_ifs = a_ifs; g_iff = a_iff; g_ief = a_ief;
                    g_ems = a_ems; g_mwb = a_mwb; g_to = a_to; g_st = int'(a_st);
                    g_ls = int'(a_ls); g_ms = int'(a_ms); g_fl = int'(a_fl);
                end else begin
                    g_pc = b_pc; g_ifs = b_ifs; g_iff = b_iff; g_ief = b_ief;
                    g_ems = b_ems; g_mwb = b_mwb; g_to = b_to; g_st = int'(b_st);
                    g_ls = int'(b_ls); g_ms = int'(b_ms); g_fl = int'(b_fl);
                end
                lu  = ex_mem_read && ex_reg_write && (ex_dst != 0) && id_reads(ex_dst);
                dep = (ex_reg_write && (ex_dst != 0) && id_reads(ex_dst)) ||
                      (mem_reg_write && (mem_dst != 0) && id_reads(mem_dst));
`ifdef HAZ_FORWARD_EN
                need = lu;
`else
                need = lu || dep;
`endif
                redir  = branch_taken || jump_taken;
                frozen = (m_mode[k] == 2) || (!dmem_ready && (m_mode[k] == 1 || dmem_req));

                chk("pc_stall", k, g_pc, frozen || (!redir && need));
                chk("if_id_stall", k, g_ifs, frozen || (!redir && need));
                chk("if_id_flush", k, g_iff, !frozen && redir);
                chk("id_ex_flush", k, g_ief,
                    !frozen && (redir ? (bstage[k] == 2) : need));
                chk("ex_mem_stall", k, g_ems, frozen);
                chk("mem_wb_bubble", k, g_mwb, frozen);
                chk("mem_timeout", k, g_to, m_mode[k] == 2);
                chk("hz_state", k, g_st, m_mode[k]);
                chk("load_stalls", k, g_ls, m_ls[k]);
                chk("mem_stalls", k, g_ms, m_ms[k]);
                chk("flushes", k, g_fl, m_fl[k]);

                if (rst) begin
                    m_mode[k] = 0; m_wait[k] = 0; m_ls[k] = 0; m_ms[k] = 0; m_fl[k] = 0;
                end else begin
                    if (frozen && m_ms[k] < cmax[k]) m_ms[k]++;
                    if (!frozen && redir && m_fl[k] < cmax[k]) m_fl[k]++;
                    if (!frozen && !redir && need && m_ls[k] < cmax[k]) m_ls[k]++;
                    if (m_mode[k] == 0) begin
                        if (dmem_req && !dmem_ready) begin
                            m_mode[k] = 1; m_wait[k] = 1;
                        end
                    end else if (m_mode[k] == 1) begin
                        if (dmem_ready) m_mode[k] = 0;
                        else if (m_wait[k] >= ModelTimeout) m_mode[k] = 2;
                        else m_wait[k]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_src_addr = '0; id_src_used = '0; ex_dst = '0; mem_dst = '0;
        ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0;
        branch_taken = 0; jump_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic load_use_8();
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd8;
        id_src_addr = {5'd8, 5'd3}; id_src_used = 2'b11;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        tick(); chk_en = 1;
        tick(); rst = 0;
        settle();
        chk("rst_hz_state", 0, a_st, 0);
        chk("rst_timeout", 0, a_to, 0);
        chk("rst_load_stalls", 1, b_ls, 0);
        chk("rst_flushes", 0, a_fl, 0);

        // Load-use on rt=8: one-cycle stall
        tick(); load_use_8();
        settle();
        chk("lu_pc_stall", 0, a_pc, 1);
        chk("lu_id_ex_flush", 1, b_ief, 1);
        chk("lu_if_id_flush", 0, a_iff, 0);
        tick(); idle();
        settle();
        chk("lu_released", 0, a_pc, 0);
        chk("lu_count", 0, a_ls, 1);
        chk("lu_count", 1, b_ls, 1);

        // Matching operand not used
        tick(); load_use_8(); id_src_used = 2'b01;
        settle();
        chk("unused_src_pc_stall", 0, a_pc, 0);

        // Register 0 never matches
        tick(); load_use_8(); ex_dst = 5'd0; id_src_addr = '0;
        settle();
        chk("r0_pc_stall", 0, a_pc, 0);

        // Memory wait of 3 cycles with concurrent branch
        tick(); idle(); dmem_req = 1; branch_taken = 1;
        settle();
        chk("mw1_hz_state", 0, a_st, 0);
        chk("mw1_mem_wb_bubble", 0, a_mwb, 1);
        chk("mw1_if_id_flush", 0, a_iff, 0);
        tick();
        settle();
        chk("mw2_hz_state", 0, a_st, 1);
        chk("mw2_id_ex_flush", 0, a_ief, 0);
        tick();
        settle();
        chk("mw3_hz_state", 1, b_st, 1);
        tick(); branch_taken = 0; dmem_ready = 1;
        settle();
        chk("mw_done_pc_stall", 0, a_pc, 0);
        tick(); idle();
        settle();
        chk("mw_back_run", 0, a_st, 0);
        chk("mw_mem_stalls", 0, a_ms, 3);
        chk("mw_mem_stalls", 1, b_ms, 3);
        chk("mw_no_flush", 0, a_fl, 0);

        // Ready in the request cycle: no stall
        tick(); dmem_req = 1; dmem_ready = 1;
        settle();
        chk("fast_mem_pc_stall", 0, a_pc, 0);

        // Timeout: ERROR after the 4th MEM_WAIT cycle
        tick(); dmem_req = 1; dmem_ready = 0;
        settle();
        chk("to_detect_state", 0, a_st, 0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            settle();
            chk("to_wait_state", 0, a_st, 1);
        end
        tick();
        settle();
        chk("to_error_state", 0, a_st, 2);
        chk("to_mem_timeout", 1, b_to, 1);
        tick(); dmem_req = 0;
        settle();
        chk("to_error_held", 0, a_st, 2);
        chk("to_error_frozen", 0, a_pc, 1);
        tick(); rst = 1;
        settle();
        tick(); rst = 0;
        settle();
        chk("to_rst_state", 0, a_st, 0);
        chk("to_rst_timeout", 0, a_to, 0);
        chk("to_rst_mem_stalls", 0, a_ms, 0);
        chk("to_rst_load_stalls", 0, a_ls, 0);

        // Branch over a load-use: redirect wins
        tick(); load_use_8(); branch_taken = 1;
        settle();
        chk("br_if_id_flush", 0, a_iff, 1);
        chk("br_id_ex_flush", 0, a_ief, 1);
        chk("br_pc_stall", 0, a_pc, 0);
        chk("br_id_ex_flush", 1, b_ief, 0);
        chk("br_pc_stall", 1, b_pc, 0);
        tick(); idle(); jump_taken = 1;
        settle();
        chk("jmp_id_ex_flush", 0, a_ief, 1);
        chk("jmp_if_id_flush", 1, b_iff, 1);
        tick(); idle();
        settle();
        chk("br_flushes", 0, a_fl, 2);
        chk("br_flushes", 1, b_fl, 2);
        chk("br_no_load_stall", 0, a_ls, 0);

        // MEM-stage producer without load
        tick(); mem_reg_write = 1; mem_dst = 5'd5; id_src_addr = {5'd0, 5'd5};
        id_src_used = 2'b01;
        settle();
`ifdef HAZ_FORWARD_EN
        chk("memdep_pc_stall", 0, a_pc, 0);
`else
        chk("memdep_pc_stall", 0, a_pc, 1);
`endif
        tick(); idle();

        // Five load-use stalls saturate the 2-bit counter
        for (int n = 0; n < 5; n++) begin
            tick(); load_use_8();
        end
        tick(); idle();
        settle();
        chk("sat_load_stalls", 1, b_ls, 3);
`ifdef HAZ_FORWARD_EN
        chk("sat_load_stalls", 0, a_ls, 5);
`else
        chk("sat_load_stalls", 0, a_ls, 6);
`endif
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
